// File: rtl/imem_loader_if.sv
// Loader control, byte-stream handshake and instruction-memory write port.
interface imem_loader_if #(
  parameter int unsigned InstrW = 24,
  parameter int unsigned AddrW  = 8
);
  logic              start;
  logic [AddrW:0]    word_count;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              we;
  logic [AddrW-1:0]  waddr;
  logic [InstrW-1:0] wdata;
  logic              busy;
  logic              done;
  logic              cpu_hold;

  modport master (
    output start, word_count, byte_in, byte_valid,
    input  byte_ready, we, waddr, wdata, busy, done, cpu_hold
  );

  modport slave (
    input  start, word_count, byte_in, byte_valid,
    output byte_ready, we, waddr, wdata, busy, done, cpu_hold
  );
endinterface

// File: rtl/imem_loader.sv
// Packs a byte stream into 24-bit big-endian instructions, writes them from address 0 upward and
// holds the fetch unit in reset until the whole program is in memory.
module imem_loader #(
  parameter int unsigned InstrW = 24,
  parameter int unsigned AddrW  = 8,
  parameter int unsigned Depth  = 256
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  imem_loader_if.slave bus_io
);

  localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(Depth);
  localparam logic [AddrW:0] CntOne   = (AddrW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [AddrW:0]    cnt_q, cnt_d;
  logic [AddrW-1:0]  waddr_q, waddr_d;
  logic [InstrW-1:0] wdata_q, wdata_d;
  logic              byte_ready_q, byte_ready_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cpu_hold_q, cpu_hold_d;

  logic [AddrW:0] start_cnt;
  logic           last_word;

  assign start_cnt = (bus_io.word_count > DepthCnt) ? DepthCnt : bus_io.word_count;
  // waddr doubles as the count of words already written.
  assign last_word = ({1'b0, waddr_q} == (cnt_q - CntOne));

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    cnt_d        = cnt_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    byte_ready_d = 1'b0;
    we_d         = 1'b0;
    busy_d       = 1'b0;
    done_d       = done_q;
    cpu_hold_d   = cpu_hold_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus_io.start) begin
          cnt_d      = start_cnt;
          waddr_d    = '0;
          byte_idx_d = '0;
          if (start_cnt == '0) begin
            state_d    = StDone;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d      = StRecv;
            byte_ready_d = 1'b1;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            cpu_hold_d   = 1'b1;
          end
        end
      end

      StRecv: begin
        busy_d       = 1'b1;
        byte_ready_d = 1'b1;
        if (bus_io.byte_valid && byte_ready_q) begin
          case (byte_idx_q)
            2'd0:    wdata_d[InstrW-1 -: 8] = bus_io.byte_in;
            2'd1:    wdata_d[InstrW-9 -: 8] = bus_io.byte_in;
            default: wdata_d[7:0]           = bus_io.byte_in;
          endcase
          if (byte_idx_q == 2'd2) begin
            state_d      = StWrite;
            byte_ready_d = 1'b0;
            we_d         = 1'b1;
            byte_idx_d   = '0;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      StWrite: begin
        if (last_word) begin
          state_d    = StDone;
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
        end else begin
          state_d      = StRecv;
          byte_ready_d = 1'b1;
          busy_d       = 1'b1;
          waddr_d      = waddr_q + AddrW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      byte_idx_q   <= '0;
      cnt_q        <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cpu_hold_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      cnt_q        <= cnt_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      byte_ready_q <= byte_ready_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cpu_hold_q   <= cpu_hold_d;
    end
  end

  assign bus_io.byte_ready = byte_ready_q;
  assign bus_io.we         = we_q;
  assign bus_io.waddr      = waddr_q;
  assign bus_io.wdata      = wdata_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.done       = done_q;
  assign bus_io.cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load scenarios, randomized loads against a byte-list model,
// and hand-written sequences for restart, ignored start and mid-load reset.
module tb_imem_loader;

  logic clk;
  logic rst_ni;

  imem_loader_if #(.InstrW(24), .AddrW(8)) bus ();

  imem_loader #(.InstrW(24), .AddrW(8), .Depth(256)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  logic [7:0]  wq_addr[$];
  logic [23:0] wq_data[$];

  // Every write pulse the DUT produces, in order.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      wq_addr.push_back(bus.waddr);
      wq_data.push_back(bus.wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  // Presents one byte and holds it until the DUT accepts it.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    int to;
    ok = 1'b1;
    to = 0;
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    @(negedge clk);
    while (bus.byte_ready !== 1'b1) begin
      to++;
      if (to > 50) begin
        nchk++;
        nerr++;
        $display("FAIL byte_ready_timeout: got ready=%b required 1", bus.byte_ready);
        bus.byte_valid = 1'b0;
        ok = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [8:0] wc);
    bus.start      = 1'b1;
    bus.word_count = wc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Model: word i of the program is bytes 3i..3i+2, big-endian, written to address i.
  task automatic compare_writes(input string tag, input logic [7:0] b[$], input int n);
    check({tag, "_write_count"}, wq_addr.size(), n);
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      check({tag, "_addr"}, wq_addr[i], i);
      check({tag, "_data"}, wq_data[i], {b[3*i], b[3*i+1], b[3*i+2]});
    end
  endtask

  task automatic run_load(input string tag, input int wc, input int n, input int gap,
                          input bit rnd_gap, input bit fixed, output bit ok);
    logic [7:0] b[$];
    logic [7:0] fixed_bytes[6];
    int g;
    fixed_bytes = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    ok = 1'b1;
    for (int i = 0; i < 3 * n; i++) begin
      if (fixed && i < 6) b.push_back(fixed_bytes[i]);
      else b.push_back(8'($urandom));
    end
    wq_addr.delete();
    wq_data.delete();
    // A byte offered alongside start must not be taken before the load begins.
    if (n > 0) begin
      bus.byte_valid = 1'b1;
      bus.byte_in    = b[0];
    end
    pulse_start(wc[8:0]);
    for (int i = 0; i < 3 * n; i++) begin
      send_byte(b[i], ok);
      if (!ok) return;
      if (i != 3 * n - 1) begin
        g = rnd_gap ? int'($urandom_range(0, gap)) : gap;
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
    end
    if (n > 0) begin
      @(negedge clk);
      check({tag, "_last_we"}, bus.we, 1'b1);
      check({tag, "_early_done"}, bus.done, 1'b0);
    end
    @(negedge clk);
    check({tag, "_done"}, bus.done, 1'b1);
    check({tag, "_cpu_hold"}, bus.cpu_hold, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    @(negedge clk);
    compare_writes(tag, b, n);
  endtask

  typedef struct {
    int wc;
    int gap;
    bit rnd_gap;
    bit fixed;
    int exp_writes;
  } vec_t;

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[6];
    bit ok;
    logic [7:0] b[$];
    int wc;

    vecs[0] = '{wc: 2,   gap: 0, rnd_gap: 1'b0, fixed: 1'b1, exp_writes: 2};
    vecs[1] = '{wc: 2,   gap: 3, rnd_gap: 1'b0, fixed: 1'b1, exp_writes: 2};
    vecs[2] = '{wc: 0,   gap: 0, rnd_gap: 1'b0, fixed: 1'b0, exp_writes: 0};
    vecs[3] = '{wc: 1,   gap: 1, rnd_gap: 1'b0, fixed: 1'b0, exp_writes: 1};
    vecs[4] = '{wc: 7,   gap: 2, rnd_gap: 1'b1, fixed: 1'b0, exp_writes: 7};
    vecs[5] = '{wc: 300, gap: 0, rnd_gap: 1'b0, fixed: 1'b0, exp_writes: 256};

    bus.start      = 1'b0;
    bus.word_count = '0;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;

    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we", bus.we, 1'b0);
    check("rst_byte_ready", bus.byte_ready, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_cpu_hold", bus.cpu_hold, 1'b1);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    foreach (vecs[i]) begin
      run_load($sformatf("vec%0d", i), vecs[i].wc, vecs[i].exp_writes, vecs[i].gap,
               vecs[i].rnd_gap, vecs[i].fixed, ok);
      if (!ok) do_reset();
    end

    for (int k = 0; k < 8; k++) begin
      wc = int'($urandom_range(0, 6));
      run_load($sformatf("rnd%0d", k), wc, wc, 2, 1'b1, 1'b0, ok);
      if (!ok) do_reset();
    end

    // Start while busy: neither restarts nor re-samples word_count.
    b.delete();
    for (int i = 0; i < 3; i++) b.push_back(8'($urandom));
    wq_addr.delete();
    wq_data.delete();
    pulse_start(9'd1);
    send_byte(b[0], ok);
    pulse_start(9'd5);
    check("busy_start_busy", bus.busy, 1'b1);
    send_byte(b[1], ok);
    send_byte(b[2], ok);
    @(negedge clk);
    check("busy_start_we", bus.we, 1'b1);
    @(negedge clk);
    check("busy_start_done", bus.done, 1'b1);
    @(negedge clk);
    compare_writes("busy_start", b, 1);

    // Reset after two bytes of word 1: partial word dropped, fetch held.
    b.delete();
    for (int i = 0; i < 5; i++) b.push_back(8'($urandom));
    wq_addr.delete();
    wq_data.delete();
    pulse_start(9'd2);
    for (int i = 0; i < 5; i++) send_byte(b[i], ok);
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(negedge clk);
    check("midrst_cpu_hold", bus.cpu_hold, 1'b1);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_ready", bus.byte_ready, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    repeat (3) @(negedge clk);
    compare_writes("midrst", b, 1);
    run_load("after_rst", 1, 1, 0, 1'b0, 1'b0, ok);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
